// File: rtl/flag_pkg.sv
// Shared encodings for the condition-flag unit: ALU op classes, flag bit
// positions inside the {N,V,C,Z} vector, and the MUL tracking FSM states.
package flag_pkg;

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_SUB   = 2'd1;
  localparam logic [1:0] OP_LOGIC = 2'd2;
  localparam logic [1:0] OP_SHIFT = 2'd3;

  localparam int FZ = 0;
  localparam int FC = 1;
  localparam int FV = 2;
  localparam int FN = 3;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/flag_unit_calc.sv
// Combinational next-flag computation for one ALU operation.
// C and V pass through from the current flags for classes that keep them.
module flag_calc
  import flag_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       op_class,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             shift_cout,
  input  logic             c_in,
  input  logic             v_in,
  output logic [3:0]       flags_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;
  logic             c;
  logic             v;

  // Select the result and derive carry/overflow for the operation class.
  always_comb begin
    sum = '0;
    r   = alu_result;
    c   = c_in;
    v   = v_in;
    case (op_class)
      OP_ADD: begin
        sum = {1'b0, opa} + {1'b0, opb};
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (opa[WIDTH-1] == opb[WIDTH-1]) && (r[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        r = opa - opb;
        c = (opa >= opb);
        v = (opa[WIDTH-1] != opb[WIDTH-1]) && (r[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SHIFT: c = shift_cout;
      default: ;
    endcase
    flags_next = {r[WIDTH-1], v, c, (r == '0)};
  end

endmodule

// File: rtl/flag_unit.sv
// Architectural Z/C/V/N flag register with MUL completion tracking,
// interrupt shadow copy, software write port and busy/error reporting.
module flag_unit
  import flag_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int MUL_LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_en,
  input  logic [1:0]       op_class,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             shift_cout,
  input  logic             mul_start,
  input  logic [WIDTH-1:0] mul_result,
  input  logic             psr_we,
  input  logic [3:0]       psr_wdata,
  input  logic             irq_save,
  input  logic             irq_restore,
  output logic             zd_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             negative_flag,
  output logic             flags_busy,
  output logic             flag_err
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       flags, flags_d, shadow, calc_flags, mul_flags;
  logic             err, err_set;
  logic             final_cyc;

  flag_calc #(.WIDTH(WIDTH)) u_calc (
    .op_class   (op_class),
    .opa        (opa),
    .opb        (opb),
    .alu_result (alu_result),
    .shift_cout (shift_cout),
    .c_in       (flags[FC]),
    .v_in       (flags[FV]),
    .flags_next (calc_flags)
  );

  assign final_cyc = (state == ST_MUL_WAIT) && (cnt == '0);
  assign mul_flags = {mul_result[WIDTH-1], flags[FV], flags[FC], (mul_result == '0)};

  // Flag priority chain: restore > software write > MUL capture > ALU update.
  // ALU updates are only honoured when no MUL is outstanding.
  always_comb begin
    flags_d = flags;
    if (irq_restore)                        flags_d = shadow;
    else if (psr_we)                        flags_d = psr_wdata;
    else if (final_cyc)                     flags_d = mul_flags;
    else if (upd_en && state == ST_IDLE)    flags_d = calc_flags;
  end

  // MUL wait tracking; restore aborts a pending wait, a new mul_start in the
  // final wait cycle chains straight into another wait.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mul_start) begin
          state_next = ST_MUL_WAIT;
          cnt_next   = CNT_LOAD;
        end
      end
      ST_MUL_WAIT: begin
        if (cnt != '0 && (mul_start || upd_en)) err_set = 1'b1;
        if (irq_restore) begin
          state_next = ST_IDLE;
        end else if (cnt == '0) begin
          if (mul_start) cnt_next = CNT_LOAD;
          else           state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, counter, flag, shadow and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      flags  <= '0;
      shadow <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      flags <= flags_d;
      if (irq_save) shadow <= flags;
      if (err_set)  err    <= 1'b1;
    end
  end

  assign zd_flag       = flags[FZ];
  assign carry_flag    = flags[FC];
  assign overflow_flag = flags[FV];
  assign negative_flag = flags[FN];
  assign flags_busy    = (state == ST_MUL_WAIT);
  assign flag_err      = err;

endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: a reference model predicts {err,busy,N,V,C,Z} for each
// clock, pushes it into a scoreboard queue and each scenario pops and compares.
module tb_flag_unit;

  localparam int W = 16;
  localparam int L = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          upd_en = 1'b0;
  logic [1:0]    op_class = 2'd0;
  logic [W-1:0]  opa = '0, opb = '0, alu_result = '0, mul_result = '0;
  logic          shift_cout = 1'b0, mul_start = 1'b0, psr_we = 1'b0;
  logic [3:0]    psr_wdata = 4'd0;
  logic          irq_save = 1'b0, irq_restore = 1'b0;
  logic          zd_flag, carry_flag, overflow_flag, negative_flag, flags_busy, flag_err;

  flag_unit #(.WIDTH(W), .MUL_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .upd_en(upd_en), .op_class(op_class),
    .opa(opa), .opb(opb), .alu_result(alu_result), .shift_cout(shift_cout),
    .mul_start(mul_start), .mul_result(mul_result), .psr_we(psr_we),
    .psr_wdata(psr_wdata), .irq_save(irq_save), .irq_restore(irq_restore),
    .zd_flag(zd_flag), .carry_flag(carry_flag), .overflow_flag(overflow_flag),
    .negative_flag(negative_flag), .flags_busy(flags_busy), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  wire [5:0] obs = {flag_err, flags_busy, negative_flag, overflow_flag, carry_flag, zd_flag};

  int        checks = 0;
  int        errors = 0;
  logic [5:0] q[$];
  logic [5:0] exp;

  // reference model state
  logic [3:0] m_flags = '0, m_shadow = '0;
  logic       m_busy = 1'b0, m_err = 1'b0;
  int         m_cnt = 0;

  function automatic logic [3:0] ref_calc(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] res,
                                          input logic sc, input logic [3:0] cur);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sbv = int'($signed(b));
    int t;
    logic [W-1:0] r = res;
    logic c = cur[1];
    logic v = cur[2];
    case (op)
      2'd0: begin t = ua + ub; r = t[W-1:0]; c = (t > 65535);
                  v = ((sa + sbv) > 32767) || ((sa + sbv) < -32768); end
      2'd1: begin t = ua - ub; r = t[W-1:0]; c = (ua >= ub);
                  v = ((sa - sbv) > 32767) || ((sa - sbv) < -32768); end
      2'd3: c = sc;
      default: ;
    endcase
    return {r[W-1], v, c, (r == 0)};
  endfunction

  task automatic model_step();
    logic [3:0] nf = m_flags;
    logic [3:0] ns = m_shadow;
    logic fin = m_busy && (m_cnt == 0);
    if (irq_restore)            nf = m_shadow;
    else if (psr_we)            nf = psr_wdata;
    else if (fin)               nf = {mul_result[W-1], m_flags[2], m_flags[1], (mul_result == 0)};
    else if (upd_en && !m_busy) nf = ref_calc(op_class, opa, opb, alu_result, shift_cout, m_flags);
    if (irq_save) ns = m_flags;
    if (!m_busy) begin
      if (mul_start) begin m_busy = 1'b1; m_cnt = L - 1; end
    end else begin
      if (m_cnt != 0 && (mul_start || upd_en)) m_err = 1'b1;
      if (irq_restore)    m_busy = 1'b0;
      else if (m_cnt == 0) begin
        if (mul_start) m_cnt = L - 1; else m_busy = 1'b0;
      end else m_cnt = m_cnt - 1;
    end
    m_flags = nf; m_shadow = ns;
    if (rst) begin
      m_flags = '0; m_shadow = '0; m_busy = 1'b0; m_err = 1'b0; m_cnt = 0;
    end
  endtask

  // Predict, push, clock, then return all pulse inputs to idle.
  task automatic cycle();
    model_step();
    q.push_back({m_err, m_busy, m_flags});
    @(posedge clk); #1;
    rst = 0; upd_en = 0; mul_start = 0; psr_we = 0; irq_save = 0; irq_restore = 0;
  endtask

  task automatic alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] res, input logic sc);
    upd_en = 1; op_class = op; opa = a; opb = b; alu_result = res; shift_cout = sc;
  endtask

  task automatic test_reset();
    rst = 1; cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_sb obs=%b exp=%b", obs, exp); end
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL reset_zero obs=%b exp=000000", obs); end
  endtask

  task automatic test_add_sub();
    alu(2'd0, 16'hFFFF, 16'h0001, '0, 0); cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL add_wrap_sb obs=%b exp=%b", obs, exp); end
    checks++;
    if (obs[3:0] !== 4'b0011) begin errors++; $display("FAIL add_wrap NVCZ=%b exp=0011", obs[3:0]); end
    alu(2'd1, 16'h8000, 16'h0001, '0, 0); cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL sub_ovf_sb obs=%b exp=%b", obs, exp); end
    checks++;
    if (obs[3:0] !== 4'b0110) begin errors++; $display("FAIL sub_ovf NVCZ=%b exp=0110", obs[3:0]); end
    alu(2'd1, 16'h0001, 16'h0002, '0, 0); cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL sub_borrow_sb obs=%b exp=%b", obs, exp); end
    checks++;
    if (obs[3:0] !== 4'b1000) begin errors++; $display("FAIL sub_borrow NVCZ=%b exp=1000", obs[3:0]); end
  endtask

  task automatic test_mul();
    psr_we = 1; psr_wdata = 4'b0110; cycle(); void'(q.pop_front());
    mul_start = 1; cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL mul_w1 obs=%b exp=%b", obs, exp); end
    cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL mul_w2 obs=%b exp=%b", obs, exp); end
    alu(2'd0, 16'h0001, 16'h0001, '0, 0); cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL mul_w3 obs=%b exp=%b", obs, exp); end
    checks++;
    if (obs !== 6'b110110) begin errors++; $display("FAIL mul_upd_err obs=%b exp=110110", obs); end
    mul_result = 16'h0000; cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL mul_done_sb obs=%b exp=%b", obs, exp); end
    checks++;
    if (obs !== 6'b100111) begin errors++; $display("FAIL mul_done obs=%b exp=100111", obs); end
  endtask

  task automatic test_back_to_back();
    rst = 1; cycle(); void'(q.pop_front());
    mul_start = 1; cycle(); void'(q.pop_front());
    cycle(); void'(q.pop_front());
    cycle(); void'(q.pop_front());
    mul_start = 1; mul_result = 16'h8000; cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL b2b_first_sb obs=%b exp=%b", obs, exp); end
    checks++;
    if (obs !== 6'b011000) begin errors++; $display("FAIL b2b_first obs=%b exp=011000", obs); end
    mul_result = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mul_result = 16'h0000;
      cycle();
      exp = q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL b2b_wait%0d obs=%b exp=%b", i, obs, exp); end
    end
    checks++;
    if (obs !== 6'b000001) begin errors++; $display("FAIL b2b_second obs=%b exp=000001", obs); end
  endtask

  task automatic test_irq();
    psr_we = 1; psr_wdata = 4'b1010; cycle(); void'(q.pop_front());
    irq_save = 1; cycle(); void'(q.pop_front());
    psr_we = 1; psr_wdata = 4'b0001; cycle(); void'(q.pop_front());
    irq_restore = 1; cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp || obs[3:0] !== 4'b1010) begin errors++; $display("FAIL irq_restore obs=%b exp=%b", obs, exp); end
    psr_we = 1; psr_wdata = 4'b0101; cycle(); void'(q.pop_front());
    irq_save = 1; irq_restore = 1; cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp || obs[3:0] !== 4'b1010) begin errors++; $display("FAIL irq_swap_flags obs=%b exp=%b", obs, exp); end
    irq_restore = 1; cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp || obs[3:0] !== 4'b0101) begin errors++; $display("FAIL irq_swap_shadow obs=%b exp=%b", obs, exp); end
    mul_start = 1; cycle(); void'(q.pop_front());
    irq_restore = 1; cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp || obs[5:4] !== 2'b00) begin errors++; $display("FAIL irq_abort obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_logic_shift();
    psr_we = 1; psr_wdata = 4'b0110; cycle(); void'(q.pop_front());
    alu(2'd2, 16'h1111, 16'h2222, 16'h8000, 1); cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp || obs[3:0] !== 4'b1110) begin errors++; $display("FAIL logic_hold obs=%b exp=%b", obs, exp); end
    alu(2'd3, 16'hFFFF, 16'hFFFF, 16'h0001, 0); cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp || obs[3:0] !== 4'b0100) begin errors++; $display("FAIL shift_c obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_rst_mul();
    mul_start = 1; cycle(); void'(q.pop_front());
    cycle(); void'(q.pop_front());
    rst = 1; cycle();
    exp = q.pop_front(); checks++;
    if (obs !== exp || obs !== 6'b000000) begin errors++; $display("FAIL rst_mul obs=%b exp=%b", obs, exp); end
    mul_result = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      exp = q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL rst_nocap%0d obs=%b exp=%b", i, obs, exp); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      upd_en      = $urandom_range(0, 1);
      op_class    = 2'($urandom_range(0, 3));
      opa         = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      opb         = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      alu_result  = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      shift_cout  = $urandom_range(0, 1);
      mul_start   = ($urandom_range(0, 5) == 0);
      mul_result  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      psr_we      = ($urandom_range(0, 9) == 0);
      psr_wdata   = 4'($urandom);
      irq_save    = ($urandom_range(0, 9) == 0);
      irq_restore = ($urandom_range(0, 14) == 0);
      cycle();
      exp = q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL random%0d obs=%b exp=%b", i, obs, exp); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_add_sub();
    test_mul();
    test_back_to_back();
    test_irq();
    test_logic_shift();
    test_rst_mul();
    test_random();
    checks++;
    if (q.size() !== 0) begin errors++; $display("FAIL sb_leftover obs=%0d exp=0", q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
